// File: rtl/tdm_demux_1to4_pkg.sv
// ============================================================================
// Module : tdm_demux_1to4_pkg
// Brief  : Shared state encodings and slot constants for the 4-slot TDM receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tdm_demux_1to4_pkg;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] SLOT_LAST = 2'd3;

endpackage

`default_nettype wire

// File: rtl/tdm_demux_1to4_slot_counter.sv
// ============================================================================
// Module : tdm_slot_counter
// Brief  : 2-bit wrapping slot counter with synchronous clear, load-to-1 and enable.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_slot_counter
    import tdm_demux_1to4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load1,
    input  logic       en,
    output logic [1:0] slot
);

    logic [1:0] r_slot;

    // Priority: reset, clear, load-to-1, then increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot <= 2'd0;
        end else if (clr) begin
            r_slot <= 2'd0;
        end else if (load1) begin
            r_slot <= 2'd1;
        end else if (en) begin
            r_slot <= (r_slot == SLOT_LAST) ? 2'd0 : r_slot + 2'd1;
        end
    end

    assign slot = r_slot;

endmodule

`default_nettype wire

// File: rtl/tdm_demux_1to4.sv
// ============================================================================
// Module : tdm_demux_1to4
// Brief  : Registered 1-to-4 TDM demultiplexer with frame alignment tracking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tdm_demux_1to4
    import tdm_demux_1to4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             frame,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             out_valid,
    output logic             s1,
    output logic             s0,
    output logic             locked,
    output logic             frame_err
);

    state_t           r_state;
    logic [1:0]       w_slot;
    logic             w_clr;
    logic             w_load1;
    logic             w_en;
    // The slot-3 beat goes straight to o3, so only slots 0..2 need a shadow.
    logic [WIDTH-1:0] r_sh0;
    logic [WIDTH-1:0] r_sh1;
    logic [WIDTH-1:0] r_sh2;
    logic [WIDTH-1:0] r_o0;
    logic [WIDTH-1:0] r_o1;
    logic [WIDTH-1:0] r_o2;
    logic [WIDTH-1:0] r_o3;
    logic             r_out_valid;
    logic             r_frame_err;

    always_comb begin
        w_clr   = 1'b0;
        w_load1 = 1'b0;
        w_en    = 1'b0;
        if (in_valid) begin
            if (frame) begin
                w_load1 = 1'b1;
            end else if (r_state == ST_LOCKED) begin
                if (w_slot == 2'd0) begin
                    w_clr = 1'b1;
                end else begin
                    w_en = 1'b1;
                end
            end
        end
    end

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .load1 (w_load1),
        .en    (w_en),
        .slot  (w_slot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_sh0       <= '0;
            r_sh1       <= '0;
            r_sh2       <= '0;
            r_o0        <= '0;
            r_o1        <= '0;
            r_o2        <= '0;
            r_o3        <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
            if (in_valid) begin
                case (r_state)
                    ST_HUNT: begin
                        if (frame) begin
                            r_sh0   <= in;
                            r_state <= ST_LOCKED;
                        end
                    end
                    ST_LOCKED: begin
                        if (frame) begin
                            // Marker mid-frame: drop the partial frame and restart.
                            if (w_slot != 2'd0) begin
                                r_frame_err <= 1'b1;
                            end
                            r_sh0 <= in;
                        end else if (w_slot == 2'd0) begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_HUNT;
                        end else begin
                            case (w_slot)
                                2'd1:      r_sh1 <= in;
                                2'd2:      r_sh2 <= in;
                                SLOT_LAST: begin
                                    r_o0        <= r_sh0;
                                    r_o1        <= r_sh1;
                                    r_o2        <= r_sh2;
                                    r_o3        <= in;
                                    r_out_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign o0        = r_o0;
    assign o1        = r_o1;
    assign o2        = r_o2;
    assign o3        = r_o3;
    assign out_valid = r_out_valid;
    assign frame_err = r_frame_err;
    assign s1        = w_slot[1];
    assign s0        = w_slot[0];
    assign locked    = (r_state == ST_LOCKED);

endmodule

`default_nettype wire
